delay_timer_multi: RTL and testbench
====================================

# delay_timer_multi

Parametrised, multi-channel successor to the single-channel digital delay timer. CHANNELS independent timers share one clock, one asynchronous reset and one free-running prescaler. Each channel offers ON-delay, OFF-delay, one-shot and ON/OFF-delay modes with a per-channel weight, an optional retrigger, and busy/done status. The block sits between debounced trigger sources and downstream actuators/control logic.

## Interface
- CHANNELS, 4, number of independent timer channels (1..16)
- WIDTH, 8, weight/counter width in bits
- PRESCALE, 1, clk cycles per timer tick (>=1); 1 means one tick per cycle
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- enable  in  1  global tick enable; low freezes the prescaler and all counters
- trigger  in  CHANNELS  per-channel trigger level, synchronous to clk
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]
- weight  in  WIDTH*CHANNELS  per-channel delay in ticks, channel i at [WIDTH*i+WIDTH-1:WIDTH*i]
- retrig  in  CHANNELS  per-channel retrigger enable (one-shot mode only)
- out  out  CHANNELS  timed output, registered
- busy  out  CHANNELS  high while the channel counter is running
- done  out  CHANNELS  one-cycle pulse when a running count expires

## Operation
- Modes: 00 ON-delay; 01 OFF-delay; 10 one-shot; 11 ON/OFF delay (both edges delayed by weight).
- Per-channel FSM: IDLE, DLY_ON, ACTIVE, DLY_OFF.
- Edge detection uses a registered copy of trigger, cleared to 0 on reset.
- mode and weight are latched on the event that starts a count. Changes mid-count take effect on the next start.
- ON-delay: rise in IDLE latches W and enters DLY_ON. Expiry gives out=1 and ACTIVE. Trigger low in DLY_ON aborts to IDLE with no done. Trigger low in ACTIVE gives out=0 and IDLE.
- OFF-delay: rise gives out=1 and ACTIVE. Fall enters DLY_OFF. Expiry gives out=0 and IDLE. A rise in DLY_OFF returns to ACTIVE with the counter cleared.
- One-shot: rise gives out=1, latches W and enters DLY_OFF regardless of trigger level. Expiry gives out=0 and IDLE. A rise during DLY_OFF reloads W if retrig=1; it is ignored if retrig=0.
- ON/OFF: ON-delay on the rising side, OFF-delay on the falling side. A fall in DLY_ON aborts to IDLE. A rise in DLY_OFF returns to ACTIVE.
- W=0: the transition happens on the same edge as the start event (zero added delay). done still pulses.
- busy=1 exactly in DLY_ON and DLY_OFF. done pulses only on counter expiry, never on abort.
- Counter is WIDTH bits, loaded with W, decremented on each tick. Expiry is defined as the counter at 1 while a tick occurs. There is no wrap: the counter never decrements below 0.

## Timing
- Reset (async, reset=0): out=0, busy=0, done=0, all FSMs IDLE, counters=0, prescaler=0, trigger history=0. This applies immediately and holds mid-count. Operation resumes on the first clk edge after reset rises.
- Tick: PRESCALE=1 gives tick every cycle while enable=1. Otherwise tick fires when the prescaler wraps from PRESCALE-1 to 0.
- Latency, PRESCALE=1: trigger rise first sampled at edge n gives busy=1 after edge n. Expiry transition and done occur at edge n+W. done falls at edge n+W+1.
- Latency, PRESCALE>1: expiry falls between (W-1)*PRESCALE+1 and W*PRESCALE cycles after the start edge.
- enable=0: prescaler, counters and FSM expiry are frozen. Level/edge transitions that need no count still occur: ON-delay output drop, OFF-delay output rise, aborts.
- Simultaneous expiry and a new edge on the same edge: the edge wins (reload or return to ACTIVE), and done is not asserted.
- Channels are fully independent. There is no arbitration.

## Structure
- Package delay_timer_pkg holds:
  - mode constants MODE_ON_DLY, MODE_OFF_DLY, MODE_ONESHOT, MODE_ONOFF;
  - the 2-bit state encoding IDLE, DLY_ON, ACTIVE, DLY_OFF.
- Sub-module delay_timer_channel implements one channel's FSM, counter and edge detection, with a tick input.
- The top level holds the shared prescaler and a generate loop over CHANNELS.

## Test plan
- Reset mid-count: ch0 one-shot with W=10; at cycle 4 assert reset=0 -> out, busy and done are 0 immediately, and stay 0 after release with trigger low.
- ON-delay, W=3, PRESCALE=1: trigger high for 10 cycles -> out rises 3 edges after the first sampled high and drops 1 edge after trigger falls. With trigger high for only 2 cycles -> out stays 0 and there is no done pulse.
- OFF-delay, W=5: trigger high for 4 cycles then low -> out rises on the first sample, falls 5 edges after the fall, and done pulses once. A re-rise at fall+2 -> out stays 1 with no done.
- One-shot, W=4, with retrig=0 and retrig=1: second rise 2 cycles after the first -> with retrig=0, out is high 4 cycles; with retrig=1, out is high 6 cycles.
- Multichannel plus prescaler, CHANNELS=4 and PRESCALE=3, each channel in a different mode with W=2: concurrent triggers -> each channel matches its single-channel model. With enable low for 5 cycles mid-count -> expiry is shifted by exactly 5 cycles.
- Edge cases: W=0 one-shot -> out stays 0 and done pulses at edge n. With W=255 and WIDTH=8 -> expiry at n+255 with no wrap.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// Shared mode and state encodings for the multi-channel delay timer.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    MODE_ON_DLY  = 2'b00,
    MODE_OFF_DLY = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_ONOFF   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DLY_ON  = 2'b01,
    ACTIVE  = 2'b10,
    DLY_OFF = 2'b11
  } state_e;

endpackage

// File: rtl/delay_timer_channel.sv
// One timer channel: trigger edge detection, mode FSM and a down-counter
// advanced by the shared tick.
module delay_timer_channel
  import delay_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             trigger,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] weight,
  input  logic             retrig,
  output logic             out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_in;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             trig_q;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             rise, expire, w_zero;

  assign mode_in = mode_e'(mode);
  assign rise    = trigger & ~trig_q;
  assign expire  = tick && (cnt_q == WIDTH'(1));
  assign w_zero  = (weight == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_ON_DLY;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      trig_q  <= trigger;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // A new edge is checked before expiry so it wins when both land together.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    out_d   = out_q;
    done_d  = 1'b0;
    cnt_d   = (tick && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          mode_d = mode_in;
          case (mode_in)
            MODE_OFF_DLY: begin
              state_d = ACTIVE;
              out_d   = 1'b1;
            end
            MODE_ONESHOT: begin
              if (w_zero) begin
                done_d = 1'b1;
              end else begin
                state_d = DLY_OFF;
                out_d   = 1'b1;
                cnt_d   = weight;
              end
            end
            default: begin
              if (w_zero) begin
                state_d = ACTIVE;
                out_d   = 1'b1;
                done_d  = 1'b1;
              end else begin
                state_d = DLY_ON;
                cnt_d   = weight;
              end
            end
          endcase
        end
      end
      DLY_ON: begin
        if (!trigger) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = ACTIVE;
          out_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (!trigger) begin
          if (mode_q == MODE_ON_DLY) begin
            state_d = IDLE;
            out_d   = 1'b0;
          end else if (w_zero) begin
            state_d = IDLE;
            out_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = DLY_OFF;
            cnt_d   = weight;
          end
        end
      end
      DLY_OFF: begin
        if (rise && mode_q != MODE_ONESHOT) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (rise && retrig) begin
          if (w_zero) begin
            state_d = IDLE;
            out_d   = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = weight;
          end
        end else if (expire) begin
          state_d = IDLE;
          out_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == DLY_ON) || (state_q == DLY_OFF);
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: rtl/delay_timer_multi.sv
// CHANNELS independent delay timers sharing one free-running prescaler
// that produces the counting tick.
module delay_timer_multi
  import delay_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [WIDTH*CHANNELS-1:0] weight,
  input  logic [CHANNELS-1:0]       retrig,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Tick fires on the wrap from PRESCALE-1 back to 0; enable low freezes it.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (enable) begin
      if (PRESCALE == 1) begin
        tick = 1'b1;
      end else if (presc_q == PW'(PRESCALE - 1)) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    delay_timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .trigger(trigger[i]),
      .mode   (mode[2*i +: 2]),
      .weight (weight[WIDTH*i +: WIDTH]),
      .retrig (retrig[i]),
      .out    (out[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

endmodule

// File: tb/tb_delay_timer_multi.sv
// Self-checking bench: two DUTs (PRESCALE 1 and 3) share stimulus and are
// compared every cycle against a deadline-based behavioural model.
module tb_delay_timer_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  trigger;
  logic [7:0]  mode;
  logic [31:0] weight;
  logic [3:0]  retrig;
  logic [3:0]  out_a, busy_a, done_a;
  logic [3:0]  out_b, busy_b, done_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model: a channel is either off/on, optionally with a pending change that
  // completes when the instance's tick total reaches an absolute deadline.
  bit         m_prev  [2][4];
  bit         m_on    [2][4];
  bit         m_run   [2][4];
  bit         m_runon [2][4];
  bit         m_done  [2][4];
  int         m_dl    [2][4];
  logic [1:0] m_mode  [2][4];
  int         en_cnt  [2];
  int         tick_cnt[2];

  delay_timer_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE(1)) u_dut_p1 (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .mode(mode),
    .weight(weight), .retrig(retrig), .out(out_a), .busy(busy_a), .done(done_a)
  );

  delay_timer_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE(3)) u_dut_p3 (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .mode(mode),
    .weight(weight), .retrig(retrig), .out(out_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int presOf(input int ii);
    return (ii == 0) ? 1 : 3;
  endfunction

  task automatic modelReset();
    for (int ii = 0; ii < 2; ii++) begin
      en_cnt[ii]   = 0;
      tick_cnt[ii] = 0;
      for (int c = 0; c < 4; c++) begin
        m_prev[ii][c]  = 1'b0;
        m_on[ii][c]    = 1'b0;
        m_run[ii][c]   = 1'b0;
        m_runon[ii][c] = 1'b0;
        m_done[ii][c]  = 1'b0;
        m_dl[ii][c]    = 0;
        m_mode[ii][c]  = 2'd0;
      end
    end
  endtask

  task automatic modelStep();
    bit         tk, t, rise, expire;
    int         w;
    logic [1:0] md;
    if (!reset) begin
      modelReset();
      return;
    end
    for (int ii = 0; ii < 2; ii++) begin
      tk = 1'b0;
      if (enable) begin
        en_cnt[ii]++;
        if (en_cnt[ii] % presOf(ii) == 0) begin
          tk = 1'b1;
          tick_cnt[ii]++;
        end
      end
      for (int c = 0; c < 4; c++) begin
        t      = trigger[c];
        rise   = t && !m_prev[ii][c];
        md     = mode[2*c +: 2];
        w      = int'(weight[8*c +: 8]);
        expire = m_run[ii][c] && tk && (tick_cnt[ii] == m_dl[ii][c]);
        m_done[ii][c] = 1'b0;
        if (!m_run[ii][c] && !m_on[ii][c]) begin
          if (rise) begin
            m_mode[ii][c] = md;
            if (md == 2'd1) begin
              m_on[ii][c] = 1'b1;
            end else if (md == 2'd2) begin
              if (w == 0) m_done[ii][c] = 1'b1;
              else begin
                m_on[ii][c] = 1'b1; m_run[ii][c] = 1'b1; m_runon[ii][c] = 1'b0;
                m_dl[ii][c] = tick_cnt[ii] + w;
              end
            end else begin
              if (w == 0) begin
                m_on[ii][c] = 1'b1; m_done[ii][c] = 1'b1;
              end else begin
                m_run[ii][c] = 1'b1; m_runon[ii][c] = 1'b1;
                m_dl[ii][c] = tick_cnt[ii] + w;
              end
            end
          end
        end else if (!m_run[ii][c]) begin
          if (!t) begin
            if (m_mode[ii][c] == 2'd0) m_on[ii][c] = 1'b0;
            else if (w == 0) begin
              m_on[ii][c] = 1'b0; m_done[ii][c] = 1'b1;
            end else begin
              m_run[ii][c] = 1'b1; m_runon[ii][c] = 1'b0;
              m_dl[ii][c] = tick_cnt[ii] + w;
            end
          end
        end else if (m_runon[ii][c]) begin
          if (!t) m_run[ii][c] = 1'b0;
          else if (expire) begin
            m_run[ii][c] = 1'b0; m_on[ii][c] = 1'b1; m_done[ii][c] = 1'b1;
          end
        end else begin
          if (rise && m_mode[ii][c] != 2'd2) begin
            m_run[ii][c] = 1'b0;
          end else if (rise && retrig[c]) begin
            if (w == 0) begin
              m_run[ii][c] = 1'b0; m_on[ii][c] = 1'b0; m_done[ii][c] = 1'b1;
            end else begin
              m_dl[ii][c] = tick_cnt[ii] + w;
            end
          end else if (expire) begin
            m_run[ii][c] = 1'b0; m_on[ii][c] = 1'b0; m_done[ii][c] = 1'b1;
          end
        end
        m_prev[ii][c] = t;
      end
    end
  endtask

  task automatic cmpVec(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic checkLit(input string name, input logic act, input logic exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cmpInt(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] eo, eb, ed;
    for (int ii = 0; ii < 2; ii++) begin
      for (int c = 0; c < 4; c++) begin
        eo[c] = m_on[ii][c];
        eb[c] = m_run[ii][c];
        ed[c] = m_done[ii][c];
      end
      if (ii == 0) begin
        cmpVec("p1_out", out_a, eo);
        cmpVec("p1_busy", busy_a, eb);
        cmpVec("p1_done", done_a, ed);
      end else begin
        cmpVec("p3_out", out_b, eo);
        cmpVec("p3_busy", busy_b, eb);
        cmpVec("p3_done", done_b, ed);
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] t, input logic e);
    trigger = t;
    enable  = e;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic setCh(input int c, input logic [1:0] md, input logic [7:0] w, input logic rt);
    mode[2*c +: 2]   = md;
    weight[8*c +: 8] = w;
    retrig[c]        = rt;
  endtask

  task automatic doReset();
    reset   = 1'b0;
    trigger = 4'b0000;
    modelReset();
    #1;
    checkOutput();
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] tn;
    int         cnt_hi, first_a, first_b;
    reset   = 1'b0;
    enable  = 1'b1;
    trigger = 4'b0000;
    mode    = '0;
    weight  = '0;
    retrig  = '0;
    doReset();

    // Reset mid-count on a one-shot.
    setCh(0, 2'd2, 8'd10, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1);
    checkLit("rst_pre_out", out_a[0], 1'b1);
    checkLit("rst_pre_busy", busy_a[0], 1'b1);
    reset = 1'b0;
    #1;
    checkLit("rst_imm_out", out_a[0], 1'b0);
    checkLit("rst_imm_busy", busy_a[0], 1'b0);
    checkLit("rst_imm_done", done_a[0], 1'b0);
    checkLit("rst_imm_out_p3", out_b[0], 1'b0);
    modelReset();
    checkOutput();
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 1'b1);
      checkLit("rst_post_out", out_a[0], 1'b0);
      checkLit("rst_post_busy", busy_a[0], 1'b0);
    end

    // ON-delay W=3, long and short trigger.
    doReset();
    setCh(0, 2'd0, 8'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0001, 1'b1);
      if (i == 0) checkLit("ond_busy_n", busy_a[0], 1'b1);
      if (i == 2) checkLit("ond_out_n2", out_a[0], 1'b0);
      if (i == 3) begin
        checkLit("ond_out_n3", out_a[0], 1'b1);
        checkLit("ond_done_n3", done_a[0], 1'b1);
      end
      if (i == 4) checkLit("ond_done_n4", done_a[0], 1'b0);
    end
    applyStimulus(4'b0000, 1'b1);
    checkLit("ond_out_drop", out_a[0], 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i < 2) ? 4'b0001 : 4'b0000, 1'b1);
      checkLit("ond_short_out", out_a[0], 1'b0);
      checkLit("ond_short_done", done_a[0], 1'b0);
    end

    // OFF-delay W=5, clean expiry then a re-rise at fall+2.
    doReset();
    setCh(0, 2'd1, 8'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 1'b1);
      if (i == 0) checkLit("offd_out_rise", out_a[0], 1'b1);
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(4'b0000, 1'b1);
      if (j == 0) checkLit("offd_busy_f", busy_a[0], 1'b1);
      if (j == 4) checkLit("offd_out_f4", out_a[0], 1'b1);
      if (j == 5) begin
        checkLit("offd_out_f5", out_a[0], 1'b0);
        checkLit("offd_done_f5", done_a[0], 1'b1);
      end
      if (j == 6) checkLit("offd_done_f6", done_a[0], 1'b0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 1'b1);
      checkLit("offd_rerise_out", out_a[0], 1'b1);
      checkLit("offd_rerise_done", done_a[0], 1'b0);
    end
    for (int i = 0; i < 8; i++) applyStimulus(4'b0000, 1'b1);

    // One-shot W=4, second rise two cycles later, without and with retrigger.
    for (int rt = 0; rt < 2; rt++) begin
      doReset();
      setCh(0, 2'd2, 8'd4, rt[0]);
      cnt_hi = 0;
      for (int i = 0; i < 12; i++) begin
        applyStimulus((i == 0 || i == 2) ? 4'b0001 : 4'b0000, 1'b1);
        if (out_a[0]) cnt_hi++;
      end
      cmpInt(rt ? "oneshot_retrig_len" : "oneshot_len", cnt_hi, rt ? 6 : 4);
    end

    // Four modes at W=2 on the PRESCALE=3 DUT, then an enable gap.
    doReset();
    setCh(0, 2'd0, 8'd2, 1'b0);
    setCh(1, 2'd1, 8'd2, 1'b0);
    setCh(2, 2'd2, 8'd2, 1'b0);
    setCh(3, 2'd3, 8'd2, 1'b0);
    first_a = -1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i < 12) ? 4'b1111 : 4'b0000, 1'b1);
      if (first_a < 0 && done_b[2]) first_a = i;
    end
    cmpInt("p3_oneshot_expiry", first_a, 5);
    doReset();
    first_b = -1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i < 12) ? 4'b1111 : 4'b0000, !(i >= 2 && i <= 6));
      if (first_b < 0 && done_b[2]) first_b = i;
    end
    cmpInt("p3_enable_gap_expiry", first_b, 10);
    cmpInt("p3_enable_gap_shift", first_b - first_a, 5);

    // W=0 one-shot: no output, immediate done.
    doReset();
    setCh(0, 2'd2, 8'd0, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkLit("w0_out", out_a[0], 1'b0);
    checkLit("w0_done", done_a[0], 1'b1);
    checkLit("w0_busy", busy_a[0], 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkLit("w0_done_next", done_a[0], 1'b0);

    // W=255 one-shot: full count without wrap.
    doReset();
    setCh(0, 2'd2, 8'd255, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    for (int i = 1; i < 260; i++) begin
      applyStimulus(4'b0000, 1'b1);
      if (i == 254) begin
        checkLit("w255_out_254", out_a[0], 1'b1);
        checkLit("w255_done_254", done_a[0], 1'b0);
      end
      if (i == 255) begin
        checkLit("w255_out_255", out_a[0], 1'b0);
        checkLit("w255_done_255", done_a[0], 1'b1);
      end
    end

    // Randomized traffic: mode/weight changes mid-count, enable dropouts.
    doReset();
    tn = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
        tn = 4'b0000;
      end
      if ($urandom_range(0, 7) == 0)
        setCh($urandom_range(0, 3), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? 8'($urandom_range(7, 20)) : 8'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)));
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) tn[c] = ~tn[c];
      applyStimulus(tn, $urandom_range(0, 9) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
